// File: rtl/cordic_rotate_sched.sv
// Round-robin scheduler in front of one shared fixed-latency CORDIC rotator.
// Issue is credit-limited so the in-order result FIFO can never overflow.
module cordic_rotate_sched #(
  parameter int N_REQ = 4,
  parameter int LAT   = 16,
  parameter int DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [16*N_REQ-1:0]  req_x,
  input  logic [16*N_REQ-1:0]  req_y,
  input  logic [32*N_REQ-1:0]  req_angle,
  output logic [15:0]          cr_x,
  output logic [15:0]          cr_y,
  output logic [31:0]          cr_angle,
  input  logic [15:0]          cr_x_res,
  input  logic [15:0]          cr_y_res,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_x,
  output logic [15:0]          rsp_y,
  output logic [2:0]           rsp_tag,
  output logic                 busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 35;
  localparam logic [PW:0]   NREQ_W    = (PW+1)'(N_REQ);
  localparam logic [CW:0]   DEPTH_W   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL_W    = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

  logic                 run_r;
  logic [PW-1:0]        ptr_r;
  logic [PW-1:0]        sel_s;
  logic [PW:0]          idx_s;
  logic                 found_s;
  logic [N_REQ-1:0]     grant_s;
  logic                 permit_s;
  logic                 accept_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 wr_en_s;
  logic [CW-1:0]        in_flight_r;
  logic [CW-1:0]        fifo_count_r;
  logic [LAT:0]         vld_pipe_r;
  logic [2:0]           tag_pipe_r [0:LAT];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [EW-1:0]        mem_r [0:DEPTH-1];
  logic [EW-1:0]        head_s;

  // Round-robin search: first valid requester at or after ptr_r.
  always_comb begin
    found_s = 1'b0;
    sel_s   = {PW{1'b0}};
    idx_s   = {(PW+1){1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = {1'b0, ptr_r} + (PW+1)'(k);
      if (idx_s >= NREQ_W) begin
        idx_s = idx_s - NREQ_W;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_valid[idx_s[PW-1:0]]) begin
        found_s = 1'b1;
        sel_s   = idx_s[PW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Credits count everything issued but not yet popped, so a pop frees one next cycle.
  assign permit_s = ({1'b0, in_flight_r} + {1'b0, fifo_count_r}) < DEPTH_W;

  // Grant gated by the issue permit and by the post-reset run flag.
  always_comb begin
    grant_s        = {N_REQ{1'b0}};
    grant_s[sel_s] = found_s;
    if (run_r && permit_s) begin
      req_ready = grant_s;
    end else begin
      req_ready = {N_REQ{1'b0}};
    end
  end

  assign accept_s  = |req_ready;
  assign push_s    = vld_pipe_r[LAT];
  assign rsp_valid = (fifo_count_r != {CW{1'b0}});
  assign pop_s     = rsp_valid & rsp_ready;
  assign full_s    = (fifo_count_r == FULL_W);
  assign wr_en_s   = push_s & (~full_s | pop_s);
  assign head_s    = mem_r[rd_ptr_r];
  assign rsp_tag   = rsp_valid ? head_s[34:32] : 3'd0;
  assign rsp_x     = rsp_valid ? head_s[31:16] : 16'd0;
  assign rsp_y     = rsp_valid ? head_s[15:0]  : 16'd0;
  assign busy      = (in_flight_r != {CW{1'b0}}) | rsp_valid;

  // Arbiter pointer, run flag, rotator operand registers and in-flight count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_r       <= 1'b0;
      ptr_r       <= {PW{1'b0}};
      cr_x        <= 16'd0;
      cr_y        <= 16'd0;
      cr_angle    <= 32'd0;
      in_flight_r <= {CW{1'b0}};
    end else begin
      run_r       <= 1'b1;
      in_flight_r <= in_flight_r + CW'(accept_s) - CW'(push_s);
      if (accept_s) begin
        ptr_r    <= ({1'b0, sel_s} + (PW+1)'(1) >= NREQ_W) ? {PW{1'b0}} : sel_s + PW'(1);
        cr_x     <= req_x[16*int'(sel_s) +: 16];
        cr_y     <= req_y[16*int'(sel_s) +: 16];
        cr_angle <= req_angle[32*int'(sel_s) +: 32];
      end else begin
        ptr_r    <= ptr_r;
        cr_x     <= 16'd0;
        cr_y     <= 16'd0;
        cr_angle <= 32'd0;
      end
    end
  end

  // Tag/valid shift register aligned so stage LAT meets the rotator result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_r <= {(LAT+1){1'b0}};
      for (int i = 0; i <= LAT; i++) begin
        tag_pipe_r[i] <= 3'd0;
      end
    end else begin
      vld_pipe_r    <= {vld_pipe_r[LAT-1:0], accept_s};
      tag_pipe_r[0] <= 3'(sel_s);
      for (int i = 1; i <= LAT; i++) begin
        tag_pipe_r[i] <= tag_pipe_r[i-1];
      end
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      fifo_count_r <= {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_SLOT) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_SLOT) ? {AW{1'b0}} : rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({wr_en_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
        2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // Result storage; contents are only visible through the valid-gated head.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {tag_pipe_r[LAT], cr_x_res, cr_y_res};
    end
  end

endmodule

// File: tb/tb_cordic_rotate_sched.sv
// Bench for cordic_rotate_sched: stand-in rotator plus a queue-based reference
// model of arbitration, credits and in-order result delivery.
module tb_cordic_rotate_sched;
  localparam int N = 4;
  localparam int LAT = 16;
  localparam int DEPTH = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid, req_ready;
  logic [16*N-1:0]   req_x, req_y;
  logic [32*N-1:0]   req_angle;
  logic [15:0]       cr_x, cr_y, cr_x_res, cr_y_res;
  logic [31:0]       cr_angle;
  logic              rsp_valid, rsp_ready, busy;
  logic [15:0]       rsp_x, rsp_y;
  logic [2:0]        rsp_tag;

  always #5 clock = ~clock;

  cordic_rotate_sched #(.N_REQ(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_angle(req_angle),
    .cr_x(cr_x), .cr_y(cr_y), .cr_angle(cr_angle),
    .cr_x_res(cr_x_res), .cr_y_res(cr_y_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_tag(rsp_tag), .busy(busy)
  );

  function automatic logic [31:0] rot(input logic [15:0] x, input logic [15:0] y, input logic [31:0] a);
    return {x + a[31:16], y ^ a[15:0]};
  endfunction

  // Stand-in rotator: LAT register stages.
  logic [31:0] rot_pipe [0:LAT-1];
  always @(posedge clock) begin
    rot_pipe[0] <= rot(cr_x, cr_y, cr_angle);
    for (int k = 1; k < LAT; k++) rot_pipe[k] <= rot_pipe[k-1];
  end
  assign cr_x_res = rot_pipe[LAT-1][31:16];
  assign cr_y_res = rot_pipe[LAT-1][15:0];

  typedef struct {
    logic [2:0]  tag;
    logic [31:0] res;
    int          rdy;
  } ent_t;

  ent_t        q[$];
  int          ptr_m, edge_n, n_acc;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] ox [N];
  logic [15:0] oy [N];
  logic [31:0] oa [N];
  logic [15:0] ecr_x, ecr_y;
  logic [31:0] ecr_a;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ptr_m = 0; edge_n = 0;
    ecr_x = 16'd0; ecr_y = 16'd0; ecr_a = 32'd0;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      ox[i] = 16'($urandom); oy[i] = 16'($urandom); oa[i] = $urandom;
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic [N-1:0] v, input logic rr);
    logic [N-1:0] eready;
    int   g;
    logic hv;
    ent_t e;
    for (int i = 0; i < N; i++) begin
      req_x[16*i +: 16] = ox[i]; req_y[16*i +: 16] = oy[i]; req_angle[32*i +: 32] = oa[i];
    end
    req_valid = v; rsp_ready = rr;
    #1;
    eready = '0; g = -1;
    if (q.size() < DEPTH)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
    if (g >= 0) eready[g] = 1'b1;
    hv = (q.size() > 0) && (q[0].rdy <= edge_n);
    chk("req_ready", 64'(req_ready), 64'(eready));
    chk("rsp_valid", 64'(rsp_valid), 64'(hv));
    if (hv) begin
      chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
      chk("rsp_x", 64'(rsp_x), 64'(q[0].res[31:16]));
      chk("rsp_y", 64'(rsp_y), 64'(q[0].res[15:0]));
    end
    chk("busy", 64'(busy), 64'(q.size() != 0));
    chk("cr_x", 64'(cr_x), 64'(ecr_x));
    chk("cr_angle", 64'(cr_angle), 64'(ecr_a));
    if (req_ready != '0) n_acc++;
    @(posedge clock);
    edge_n++;
    if (hv && rr) void'(q.pop_front());
    if (g >= 0) begin
      e.tag = 3'(g); e.res = rot(ox[g], oy[g], oa[g]); e.rdy = edge_n + LAT + 1;
      q.push_back(e);
      ecr_x = ox[g]; ecr_y = oy[g]; ecr_a = oa[g];
      ptr_m = (g + 1) % N;
    end else begin
      ecr_x = 16'd0; ecr_y = 16'd0; ecr_a = 32'd0;
    end
    @(negedge clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) step('0, 1'b1);
    chk("drain_bound", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_cr_x"}, 64'(cr_x), 64'd0);
    chk({tag, "_cr_angle"}, 64'(cr_angle), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_xytag"}, 64'({rsp_x, rsp_y, rsp_tag}), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; rsp_ready = 1'b0; req_valid = '1;
    req_x = '1; req_y = '1; req_angle = '1;
    repeat (2) @(negedge clock);
    #1 check_reset_outputs("reset");
    req_valid = '0;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); @(negedge clock);
    model_reset();

    // Single request from requester 2.
    randomize_ops();
    ox[2] = 16'd1000; oy[2] = 16'd0; oa[2] = 32'h2000_0000;
    step(4'b0100, 1'b1);
    drain();
    step('0, 1'b1);

    // All requesters valid, consumer always ready.
    for (int i = 0; i < 40; i++) begin randomize_ops(); step(4'b1111, 1'b1); end
    drain();

    // Consumer stalled: exactly DEPTH accepts, then full-FIFO push/pop traffic.
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin randomize_ops(); step(4'b1111, 1'b0); end
    chk("fill_accepts", 64'(n_acc), 64'(DEPTH));
    for (int i = 0; i < 60; i++) begin randomize_ops(); step(4'b1111, 1'b1); end
    drain();

    // Grant to 1, then only 3 valid: 3 immediately, then pointer at 0.
    randomize_ops(); step(4'b0010, 1'b1);
    randomize_ops(); step(4'b1000, 1'b1);
    randomize_ops(); step(4'b1111, 1'b1);
    drain();

    // Random traffic and random backpressure.
    for (int i = 0; i < 400; i++) begin
      randomize_ops();
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    drain();

    // Reset with operations in flight.
    for (int i = 0; i < 10; i++) begin randomize_ops(); step(4'b1111, 1'b0); end
    req_valid = '1;
    reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clock);
    req_valid = '0; reset_n = 1'b1;
    @(posedge clock); @(negedge clock);
    model_reset();
    for (int i = 0; i < 2*LAT + 2; i++) step('0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      randomize_ops();
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_rotate_sched.md
CORDIC_ROTATE_SCHED -- requirements
Module: cordic_rotate_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one pipelined rotator; legal range 2..8.
REQ-002 Parameter LAT, default 16: fixed rotator latency in clock cycles, from operands on cr_* to result on cr_x_res/cr_y_res.
REQ-003 Parameter DEPTH, default 16: result FIFO entries; legal range 2..64.
REQ-004 One clock; reset is asynchronous and active-low: clock  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  N_REQ  per-requester request strobe.
REQ-007 req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_x, req_y  in  16*N_REQ each  signed operands; slice i belongs to requester i.
REQ-009 req_angle  in  32*N_REQ  angle; full circle = 2^32.
REQ-010 cr_x, cr_y  out  16 each  registered operands to the rotator.
REQ-011 cr_angle  out  32  registered angle to the rotator.
REQ-012 cr_x_res, cr_y_res  in  16 each  rotator results.
REQ-013 rsp_valid  out  1  result available at FIFO head.
REQ-014 rsp_ready  in  1  consumer accepts the head entry.
REQ-015 rsp_x, rsp_y  out  16 each  head result.
REQ-016 rsp_tag  out  3  index of the requester that issued the head result.
REQ-017 busy  out  1  high while any operation is in flight or the FIFO is non-empty.

Function
REQ-018 Accept for requester i: req_valid[i] and req_ready[i] both high at a rising edge.
REQ-019 req_ready is combinational: the grant from the round-robin arbiter, gated by the issue-permit condition.
REQ-020 Issue permit: in_flight + fifo_count < DEPTH, where in_flight counts accepted results not yet written to the FIFO.
REQ-021 A FIFO pop in the current cycle does not free a credit until the next cycle.
REQ-022 Arbitration: round-robin pointer ptr, reset 0.
REQ-023 Grant goes to the first asserted req_valid, searching ptr, ptr+1, ... (mod N_REQ).
REQ-024 On an accept by requester i, ptr becomes (i+1) mod N_REQ; with no accept, ptr holds.
REQ-025 A requester holding req_valid high is granted within N_REQ permitted cycles.
REQ-026 On an accept, the selected operands are registered onto cr_x/cr_y/cr_angle; in cycles with no accept, cr_* are driven to 0.
REQ-027 Throughput: one accept per cycle while the permit holds.
REQ-028 The tag and valid bit travel a shift register aligned to LAT.
REQ-029 For an accept at edge E, cr_x_res/cr_y_res are sampled and pushed to the FIFO with that tag at edge E+LAT+1.
REQ-030 rsp_valid then rises after edge E+LAT+1 when the FIFO was empty.
REQ-031 Results leave the FIFO in issue order; rsp_* are stable while rsp_valid is high and rsp_ready is low.
REQ-032 A pop occurs when rsp_valid and rsp_ready are high at an edge.
REQ-033 A simultaneous push and pop at any occupancy, including full, keeps fifo_count unchanged and drops no data.
REQ-034 in_flight and fifo_count never exceed DEPTH, so the FIFO never overflows.
REQ-035 FIFO pointers wrap modulo DEPTH.
REQ-036 A pop with the FIFO empty has no effect.
REQ-037 rsp_tag is zero-extended to 3 bits for N_REQ < 8.

Reset
REQ-038 While reset_n is low: req_ready=0, cr_*=0, rsp_valid=0, rsp_x=rsp_y=rsp_tag=0, busy=0, ptr=0, in_flight=0, fifo_count=0, and tag-pipe valid bits are 0.
REQ-039 Reset asserted mid-operation discards all in-flight and buffered results; no stale result appears after release.
REQ-040 req_ready may first go high in the first cycle after reset_n rises.

Verification
REQ-041 Single request: requester 2 sends x=1000, y=0, angle=0x20000000 (45 deg) -> accepted next edge; rsp_valid exactly LAT+1 edges later with rsp_tag=2 and rsp_* equal to rotator output; busy falls after the pop.
REQ-042 All four requesters valid continuously, rsp_ready=1 -> grants go 0,1,2,3,0,... one per cycle; rsp_tag sequence matches; no request waits more than 4 cycles.
REQ-043 rsp_ready=0 with DEPTH=16 -> exactly 16 accepts, then req_ready stays 0; FIFO full and no overflow; raising rsp_ready resumes accepts one cycle after the first pop.
REQ-044 FIFO full with an arriving push and a same-cycle pop -> fifo_count stays 16; output order preserved across pointer wrap.
REQ-045 reset_n pulsed low with 10 operations in flight -> all outputs 0 immediately; no rsp_valid for 2*LAT cycles after release when there are no new requests.
REQ-046 Only requester 3 valid after a grant to 1 -> requester 3 granted at once; ptr then 0.
